// File: rtl/diagv2_dmem_pkg.sv
// Shared constants and load/alignment helpers for the diagv2 data-memory responder.
package diagv2_dmem_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } mem_size_e;

    localparam int MT_UNSIGNED_BIT = 2;

    localparam logic [4:0] OFF_CONSOLE_TX   = 5'h00;
    localparam logic [4:0] OFF_CONSOLE_STAT = 5'h08;
    localparam logic [4:0] OFF_TIMER        = 5'h10;
    localparam logic [4:0] OFF_TIMECMP      = 5'h18;

    // Register slot within the 32-byte window, i.e. offset[4:3].
    typedef enum logic [1:0] {
        REG_CONSOLE_TX   = 2'd0,
        REG_CONSOLE_STAT = 2'd1,
        REG_TIMER        = 2'd2,
        REG_TIMECMP      = 2'd3
    } mmio_reg_e;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic is_aligned(input logic [2:0] lane, input logic [1:0] sz);
        logic ok;
        case (mem_size_e'(sz))
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (lane[0] == 1'b0);
            SZ_WORD: ok = (lane[1:0] == 2'b00);
            default: ok = (lane == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (mem_size_e'(sz))
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0] lane,
                                                     input logic [2:0] mtype);
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] r;
        logic            uns;
        s   = word >> {lane, 3'b000};
        uns = mtype[MT_UNSIGNED_BIT];
        case (mem_size_e'(mtype[1:0]))
            SZ_BYTE: r = uns ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            SZ_HALF: r = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SZ_WORD: r = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/diagv2_dmem_console_fifo.sv
// Byte-wide synchronous FIFO for the console transmit path, with sticky overflow.
module diagv2_console_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;
    logic [7:0]    mem_q [DEPTH];

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
    // Gate the head so nothing stale is ever presented while empty.
    assign head_data = empty ? 8'd0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push && !push_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/diagv2_dmem.sv
// Data-memory responder: combinational loads, clocked stores, timer and console MMIO.
// Console FIFO and its registers exist only when DIAGV2_DMEM_CONSOLE_EN is defined.
module diagv2_dmem
    import diagv2_dmem_pkg::*;
#(
    parameter int          MEM_WORDS     = 4096,
    parameter logic [63:0] MMIO_BASE     = 64'h0000_0000_1000_0000,
    parameter int          CONSOLE_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] writeData,
    input  logic            memWrite,
    input  logic [2:0]      memType,
    output logic [XLEN-1:0] readData,
    output logic            consoleValid,
    output logic [7:0]      consoleData,
    input  logic            consoleReady,
    output logic            timerIrq,
    output logic            misaligned
);
    localparam int          WIDX      = $clog2(MEM_WORDS);
    localparam int          CNT_W     = $clog2(CONSOLE_DEPTH) + 1;
    localparam logic [63:0] RAM_BYTES = 64'(MEM_WORDS) * 64'd8;

    logic [XLEN-1:0] ram_q [MEM_WORDS];
    logic [WIDX-1:0] ram_idx;
    logic            in_ram, in_mmio;
    mmio_reg_e       mmio_reg;

    logic            aligned, store_ok, ram_we;
    logic [7:0]      ram_be;
    logic [XLEN-1:0] ram_wdata;
    logic            console_push;

    logic [XLEN-1:0] timer_q, timer_d;
    logic [XLEN-1:0] timecmp_q, timecmp_d;
    logic            irq_q, irq_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] console_stat;
    logic [XLEN-1:0] mmio_word, src_word;

    assign in_ram   = (addr < RAM_BYTES);
    assign in_mmio  = (addr >= MMIO_BASE) && (addr < MMIO_BASE + 64'd32);
    assign mmio_reg = mmio_reg_e'(2'((addr - MMIO_BASE) >> 3));
    assign ram_idx  = addr[WIDX+2:3];
    assign aligned  = is_aligned(addr[2:0], memType[1:0]);

    always_comb begin
        store_ok     = memWrite && aligned;
        ram_we       = store_ok && in_ram;
        ram_be       = byte_mask(memType[1:0]) << addr[2:0];
        ram_wdata    = writeData << {addr[2:0], 3'b000};
        console_push = store_ok && in_mmio && (mmio_reg == REG_CONSOLE_TX);
        timer_d      = timer_q + 64'd1;
        irq_d        = (timer_q >= timecmp_q);
        misaligned_d = misaligned_q | (memWrite && !aligned);
        timecmp_d    = timecmp_q;
        if (store_ok && in_mmio && (mmio_reg == REG_TIMECMP)
            && (mem_size_e'(memType[1:0]) == SZ_DOUBLE))
            timecmp_d = writeData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q      <= '0;
            timecmp_q    <= '1;
            irq_q        <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            timecmp_q    <= timecmp_d;
            irq_q        <= irq_d;
            misaligned_q <= misaligned_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (ram_be[b]) ram_q[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

`ifdef DIAGV2_DMEM_CONSOLE_EN
    logic             con_full, con_empty, con_ovf;
    logic [CNT_W-1:0] con_count;

    diagv2_console_fifo #(.DEPTH(CONSOLE_DEPTH)) u_console_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (console_push),
        .push_data (writeData[7:0]),
        .pop       (consoleReady),
        .head_data (consoleData),
        .full      (con_full),
        .empty     (con_empty),
        .count     (con_count),
        .overflow  (con_ovf)
    );

    assign consoleValid = !con_empty;

    always_comb begin
        console_stat                             = '0;
        console_stat[STAT_FULL_BIT]              = con_full;
        console_stat[STAT_EMPTY_BIT]             = con_empty;
        console_stat[STAT_OVF_BIT]               = con_ovf;
        console_stat[STAT_COUNT_LSB +: CNT_W]    = con_count;
    end
`else
    logic [1:0] console_unused;

    assign console_unused = {consoleReady, console_push};
    assign consoleValid   = 1'b0;
    assign consoleData    = 8'd0;
    assign console_stat   = '0;
`endif

    always_comb begin
        mmio_word = '0;
        case (mmio_reg)
            REG_CONSOLE_STAT: mmio_word = console_stat;
            REG_TIMER:        mmio_word = timer_q;
            REG_TIMECMP:      mmio_word = timecmp_q;
            default:          mmio_word = '0;
        endcase
        src_word = in_ram ? ram_q[ram_idx] : mmio_word;
        readData = '0;
        if (aligned && (in_ram || in_mmio))
            readData = load_extract(src_word, addr[2:0], memType);
    end

    assign timerIrq   = irq_q;
    assign misaligned = misaligned_q;

endmodule

// File: doc/diagv2_dmem.md
# diagv2_dmem

Data-memory responder for the pipelined core's memory-stage bus. It answers loads combinationally in the same cycle and commits stores on the clock edge, with per-size byte-lane handling and sign or zero extension. It also decodes a small memory-mapped I/O window containing a free-running timer with compare interrupt and a byte-wide console transmit FIFO with a valid/ready drain port. It sits beside the core and connects to its memory-stage address, store-data, write-enable and memory-type outputs and to its load-data input.

## Interface
- `MEM_WORDS`, 4096: RAM depth in 64-bit words; power of two.
- `MMIO_BASE`, 64'h0000_0000_1000_0000: base address of the I/O window, 32 bytes.
- `CONSOLE_DEPTH`, 8: console FIFO depth; power of two, at most 16.
- Reset is asynchronous and active-high; all state is in the `clk` domain.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `addr` in 64: byte address, driven by the core's ALU result in the memory stage.
- `writeData` in 64: store data, right-aligned.
- `memWrite` in 1: store strobe.
- `memType` in 3: bit 2 selects unsigned; bits [1:0] select size (0 byte, 1 half, 2 word, 3 double).
- `readData` out 64: extended load data, combinational.
- `consoleValid` out 1: FIFO head is valid.
- `consoleData` out 8: FIFO head byte.
- `consoleReady` in 1: sink accepts the head byte.
- `timerIrq` out 1: registered; high when timer ≥ compare.
- `misaligned` out 1: sticky flag for a misaligned store.

## Operation
- Region decode:
  - RAM is `addr < MEM_WORDS*8`.
  - MMIO is `MMIO_BASE ≤ addr < MMIO_BASE+32`.
  - Any other address is unmapped: loads return 0 and stores are ignored.
- RAM addressing:
  - Word index is `addr[log2(MEM_WORDS)+2:3]`; lane is `addr[2:0]`.
  - Load: take the word, shift right by 8·lane, truncate to size, then sign-extend (bit2=0) or zero-extend (bit2=1).
- Alignment:
  - An access is aligned when `addr` mod size is 0.
  - A misaligned load returns 0.
  - A misaligned store is dropped and sets `misaligned`.
  - Alignment is checked on stores only, because the core drives `addr` and `memType` on every instruction.
- RAM store: writes only the byte lanes covered by size and lane; all other lanes are unchanged. RAM contents are not cleared by reset.
- MMIO map (offsets from `MMIO_BASE`):
  - 0x00 CONSOLE_TX: a store of any size pushes `writeData[7:0]`. Reads return 0.
  - 0x08 CONSOLE_STAT, read-only:
    - bit0 full, bit1 empty, bit2 overflow (sticky).
    - bits[12:8] count.
  - 0x10 TIMER: read returns the 64-bit counter. Stores are ignored.
  - 0x18 TIMECMP: read/write; a store counts only if it is a doubleword, other sizes are ignored.
- MMIO loads apply the same lane and extension rules as RAM loads.
- Timer: increments every cycle and wraps 2^64−1 → 0. `timerIrq` is registered as (timer ≥ TIMECMP).
- Console FIFO:
  - A push is accepted if not full, or if a pop happens in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow.
  - Pop occurs when `consoleValid & consoleReady`.
  - There is no bypass: a byte pushed into an empty FIFO is visible the next cycle.
  - Read/write pointers are log2(`CONSOLE_DEPTH`) bits and wrap modulo depth; count has one extra bit.

## Timing
- Load latency is 0: `readData` is a combinational function of `addr`, `memType` and current state.
- Store commits at the rising edge where `memWrite` is high. A load to the same address in the following cycle returns the new data.
- `timerIrq` lags the compare condition by one cycle. A TIMECMP write is reflected in `timerIrq` two edges later.
- Reset values:
  - `readData` follows RAM contents.
  - `consoleValid` 0, `consoleData` 0, `timerIrq` 0, `misaligned` 0.
  - Timer 0, TIMECMP all-ones, FIFO empty, overflow 0.
- Reset asserted mid-drain clears the FIFO immediately. The byte then on `consoleData` is lost and is not re-presented.

## Configuration
- `DIAGV2_DMEM_CONSOLE_EN`:
  - Defined: the console FIFO and the CONSOLE_TX/CONSOLE_STAT registers are present.
  - Undefined: no FIFO is built, `consoleValid`=0, `consoleData`=0, offsets 0x00/0x08 read 0, and stores to them are ignored. The timer and RAM are unaffected.

## Structure
- Shared constants header:
  - memType size and unsigned encodings.
  - MMIO offsets.
  - CONSOLE_STAT bit positions.
  - Data-bus width constant.
- One sub-module: `diagv2_console_fifo`, a synchronous FIFO with push/pop, full/empty/count and sticky overflow. It is instantiated only under the macro.

## Test plan
- Store double 0x8877665544332211 at 0x100, then LB at 0x107 → 0xFFFF_FFFF_FFFF_FF88. LBU at 0x107 → 0x88. LHU at 0x102 → 0x4433.
- SH 0xBEEF at 0x10A over a zeroed word, then LD 0x108 → 0x0000_0000_BEEF_0000; the neighbouring lanes are unchanged.
- SW at 0x102 → RAM unchanged and `misaligned`=1 from the next cycle, holding until reset. LW at 0x102 → 0.
- With `consoleReady`=0, push 9 bytes → STAT full=1, count=8, overflow=1. Raise `consoleReady` → bytes 0..7 drain in order, one per cycle, then `consoleValid`=0.
- Write TIMECMP=20 at cycle 5 → `timerIrq` rises at the edge after timer reaches 20. Write TIMECMP all-ones → `timerIrq` falls.
- Assert reset while the FIFO holds 3 bytes and the timer reads 1000 → `consoleValid`=0 and timer=0 immediately, and earlier RAM data still reads back.
